monopix_ro_ctrl: RTL
====================

MONOPIX_RO_CTRL -- requirements
Module: monopix_ro_ctrl

Interface
REQ-001 Parameter COL_W, default 6, column address width.
REQ-002 Parameter TS_W, default 6, LE/TE timestamp width (Gray-coded on the serial input).
REQ-003 Parameter ROW_W, default 9, row address width; DATA_W = COL_W+2*TS_W+ROW_W (default 27).
REQ-004 Parameter WAIT_CYC, default 2, range 1..255: cycles spent in TOKEN_WAIT.
REQ-005 Parameter READ_CYC, default 2, range 1..255: cycles read is asserted.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two >= 2: output word buffer depth.
REQ-007 Port clk_bx, in, 1: single clock, all logic on rising edge.
REQ-008 Port rst_n, in, 1: asynchronous active-low reset.
REQ-009 Port enable, in, 1: permits new token service.
REQ-010 Port token, in, 1: matrix has a pending hit.
REQ-011 Port read, out, 1: read strobe to matrix.
REQ-012 Port freeze, out, 1: freeze to matrix.
REQ-013 Port data_in, in, 1: serial hit word, MSB first.
REQ-014 Port out_data, out, OUT_W: decoded word; OUT_W = DATA_W, or DATA_W+TS_W with TOT_CALC_EN.
REQ-015 Port out_valid, out, 1; port out_ready, in, 1: valid/ready output handshake.
REQ-016 Port drop_cnt, out, 16: count of words lost to a full FIFO.
REQ-017 Port busy, out, 1: high when the state is not IDLE.

Function
REQ-018 FSM states: IDLE, TOKEN_WAIT, READ, SHIFT, STORE; read, freeze and busy are decoded only from the state register.
REQ-019 IDLE->TOKEN_WAIT on an edge with enable=1 and token=1; otherwise the FSM remains in IDLE.
REQ-020 TOKEN_WAIT lasts exactly WAIT_CYC cycles, then READ.
REQ-021 READ lasts exactly READ_CYC cycles, then SHIFT.
REQ-022 SHIFT lasts exactly DATA_W cycles, sampling data_in once per edge into a shift register, MSB first.
REQ-023 STORE lasts 1 cycle, then goes to TOKEN_WAIT if token=1 and enable=1, else to IDLE.
REQ-024 read=1 only in READ; freeze=1 in TOKEN_WAIT, READ and SHIFT; freeze=0 in IDLE and STORE.
REQ-025 Deasserting enable mid-word lets the current word complete; STORE then exits to IDLE.
REQ-026 Serial word layout, MSB to LSB: col[COL_W], te_gray[TS_W], le_gray[TS_W], row[ROW_W].
REQ-027 out_data = {col, te_bin, le_bin, row}; binary conversion: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
REQ-028 In STORE the decoded word is pushed into the FIFO; out_valid = FIFO not empty (show-ahead).
REQ-029 A pop occurs when out_valid=1 and out_ready=1.
REQ-030 A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-031 A push that is not accepted discards the word and increments drop_cnt, which saturates at 16'hFFFF.
REQ-032 Latency: token sampled at edge N gives out_valid=1 after edge N+WAIT_CYC+READ_CYC+DATA_W+2 (FIFO previously empty); 33 cycles with defaults.
REQ-033 out_data is held stable while out_valid=1 and out_ready=0.

Reset
REQ-034 rst_n=0 asynchronously sets the state to IDLE and clears all counters, the shift register, the FIFO pointers and drop_cnt.
REQ-035 During reset: read=0, freeze=0, busy=0, out_valid=0, out_data=0, drop_cnt=0.
REQ-036 Reset asserted mid-word abandons the word with no push and no drop count.
REQ-037 Reset release is synchronised to clk_bx; the first token is sampled at the second edge after release.

Configuration
REQ-038 Macro TOT_CALC_EN, when defined: out_data = {tot, col, te_bin, le_bin, row} with tot = (te_bin - le_bin) mod 2^TS_W.
REQ-039 Without TOT_CALC_EN: no tot field, no subtractor is built, and OUT_W = DATA_W.

Verification
REQ-040 Defaults, one token pulse, serial col=5, te_gray=6'b000110, le_gray=6'b000011, row=100 -> one word col=5, te=4, le=2, row=100 (tot=2 with TOT_CALC_EN); out_valid rises 33 cycles after the token edge.
REQ-041 Same word -> read high for exactly 2 cycles and freeze high for exactly 31 cycles.
REQ-042 token held high for 3 words -> consecutive STORE->TOKEN_WAIT transitions with no IDLE in between; 3 words out in order.
REQ-043 FIFO_DEPTH=4, out_ready=0, 6 words sent -> 4 words buffered and drop_cnt=2; out_ready=1 then drains the 4 words in order.
REQ-044 rst_n pulsed low during SHIFT -> read, freeze and busy go 0 immediately; no word is output; the next token yields a correct word.
REQ-045 TOT_CALC_EN defined, le_bin=60, te_bin=3 -> tot=7 (wrap-around).

Source files
------------

// File: rtl/monopix_ro_ctrl.sv
// monopix_ro_ctrl: token-driven serial readout controller with Gray decode and an output word FIFO.
// Optional macro TOT_CALC_EN prepends tot = te - le (mod 2^TS_W) to every output word.
module monopix_ro_ctrl #(
    parameter int COL_W      = 6,
    parameter int TS_W       = 6,
    parameter int ROW_W      = 9,
    parameter int WAIT_CYC   = 2,
    parameter int READ_CYC   = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int DATA_W    = COL_W + 2*TS_W + ROW_W,
`ifdef TOT_CALC_EN
    localparam int OUT_W     = DATA_W + TS_W
`else
    localparam int OUT_W     = DATA_W
`endif
) (
    input  logic             clk_bx,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             token,
    output logic             read,
    output logic             freeze,
    input  logic             data_in,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      drop_cnt,
    output logic             busy
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_STORE = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                cnt_last_s;
    logic                run_en_r;
    logic                token_r;
    logic                enable_r;
    logic                start_s;
    logic [DATA_W-1:0]   shift_r;
    logic [TS_W-1:0]     te_bin_s;
    logic [TS_W-1:0]     le_bin_s;
    logic [OUT_W-1:0]    word_s;
    logic [OUT_W-1:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_r;
    logic [AW:0]         rd_ptr_r;
    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic                accept_s;
    logic [15:0]         drop_cnt_r;

    function automatic logic [TS_W-1:0] gray2bin(input logic [TS_W-1:0] g);
        logic [TS_W-1:0] b;
        b[TS_W-1] = g[TS_W-1];
        for (int i = TS_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Input capture; run_en_r holds off token sampling for one edge after reset release
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            run_en_r <= 1'b0;
            token_r  <= 1'b0;
            enable_r <= 1'b0;
        end else begin
            run_en_r <= 1'b1;
            token_r  <= token & run_en_r;
            enable_r <= enable & run_en_r;
        end
    end

    assign start_s = token_r & enable_r;

    // State register
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Last-cycle detect for the timed states
    always_comb begin
        cnt_last_s = 1'b0;
        case (state_r)
            ST_WAIT:  cnt_last_s = (cnt_r == CNT_W'(WAIT_CYC - 1));
            ST_READ:  cnt_last_s = (cnt_r == CNT_W'(READ_CYC - 1));
            ST_SHIFT: cnt_last_s = (cnt_r == CNT_W'(DATA_W - 1));
            default:  cnt_last_s = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_s)    state_s = ST_WAIT;  else state_s = ST_IDLE;
            ST_WAIT:  if (cnt_last_s) state_s = ST_READ;  else state_s = ST_WAIT;
            ST_READ:  if (cnt_last_s) state_s = ST_SHIFT; else state_s = ST_READ;
            ST_SHIFT: if (cnt_last_s) state_s = ST_STORE; else state_s = ST_SHIFT;
            ST_STORE: if (start_s)    state_s = ST_WAIT;  else state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Matrix control outputs, decoded purely from the state register
    always_comb begin
        read   = 1'b0;
        freeze = 1'b0;
        busy   = 1'b0;
        case (state_r)
            ST_IDLE:  begin read = 1'b0; freeze = 1'b0; busy = 1'b0; end
            ST_WAIT:  begin read = 1'b0; freeze = 1'b1; busy = 1'b1; end
            ST_READ:  begin read = 1'b1; freeze = 1'b1; busy = 1'b1; end
            ST_SHIFT: begin read = 1'b0; freeze = 1'b1; busy = 1'b1; end
            ST_STORE: begin read = 1'b0; freeze = 1'b0; busy = 1'b1; end
            default:  begin read = 1'b0; freeze = 1'b0; busy = 1'b0; end
        endcase
    end

    // Per-state cycle counter
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_last_s || state_r == ST_IDLE || state_r == ST_STORE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Serial capture, MSB arrives first
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            shift_r <= {shift_r[DATA_W-2:0], data_in};
        end else begin
            shift_r <= shift_r;
        end
    end

    assign te_bin_s = gray2bin(shift_r[2*TS_W+ROW_W-1 -: TS_W]);
    assign le_bin_s = gray2bin(shift_r[TS_W+ROW_W-1 -: TS_W]);

`ifdef TOT_CALC_EN
    assign word_s = {te_bin_s - le_bin_s, shift_r[DATA_W-1 -: COL_W], te_bin_s, le_bin_s,
                     shift_r[ROW_W-1:0]};
`else
    assign word_s = {shift_r[DATA_W-1 -: COL_W], te_bin_s, le_bin_s, shift_r[ROW_W-1:0]};
`endif

    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s    = !empty_s && out_ready;
    assign push_s   = (state_r == ST_STORE);
    // A full FIFO still takes the word when the head leaves in the same cycle
    assign accept_s = push_s && (!full_s || pop_s);

    // FIFO storage and pointers
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {OUT_W{1'b0}};
            end
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= word_s;
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Saturating count of discarded words
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'h0000;
        end else if (push_s && !accept_s && drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;

    // Show-ahead output; zero when nothing is buffered
    always_comb begin
        if (empty_s) begin
            out_valid = 1'b0;
            out_data  = {OUT_W{1'b0}};
        end else begin
            out_valid = 1'b1;
            out_data  = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

endmodule
